// File: rtl/prod_bcd_seg_seq.sv
// prod_bcd_seg_seq: converts a 16-bit product to five BCD digits with a
// sequential double-dabble engine. It then presents one active-low
// seven-segment digit per cycle, with its digit index and a done strobe.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading zero digits
// above the units digit.
module prod_bcd_seg_seq #(
  parameter int unsigned W    = 16,
  parameter int unsigned NDIG = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_i,
  input  logic [W-1:0]   product_i,
  output logic [6:0]     seg_out_o,
  output logic [2:0]     seg_mux_sel_o,
  output logic           done_o,
  output logic           busy_o
);

  localparam int unsigned BCD_W = 4 * NDIG;
  localparam int unsigned CNT_W = $clog2(W);
  localparam int unsigned SEL_W = 3;
  localparam int unsigned SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_ZERO  = 7'b0000001;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    EMIT  = 2'd2
  } state_t;

  state_t             state_q;
  logic [W-1:0]       bin_q;
  logic [BCD_W-1:0]   bcd_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [SEL_W-1:0]   idx_q;
  logic [SEG_W-1:0]   seg_q;
  logic [SEL_W-1:0]   sel_q;
  logic               done_q;
  logic               busy_q;

  logic [BCD_W-1:0]   bcd_adj_c;
  logic [BCD_W+W-1:0] dd_c;
  logic [BCD_W-1:0]   bcd_d;
  logic [W-1:0]       bin_d;
  logic [3:0]         digit_c;
  logic [SEG_W-1:0]   seg_d;
`ifdef LEADING_ZERO_BLANK_EN
  logic               lead_zero_c;
`endif

  // Active-low {a,b,c,d,e,f,g} pattern for one BCD digit; non-decimal codes blank.
  function automatic logic [SEG_W-1:0] enc_digit(input logic [3:0] d);
    logic [SEG_W-1:0] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // One double-dabble iteration: add 3 to nibbles >= 5, then shift {bcd, bin} left.
  always_comb begin
    bcd_adj_c = bcd_q;
    for (int i = 0; i < int'(NDIG); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj_c[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    dd_c  = {bcd_adj_c, bin_q} << 1;
    bcd_d = dd_c[BCD_W+W-1 -: BCD_W];
    bin_d = dd_c[W-1:0];
  end

  // Select the digit being emitted and encode it; optionally blank leading zeros.
  always_comb begin
    digit_c = 4'd0;
`ifdef LEADING_ZERO_BLANK_EN
    lead_zero_c = 1'b1;
`endif
    for (int i = 0; i < int'(NDIG); i++) begin
      if (idx_q == SEL_W'(i)) begin
        digit_c = bcd_q[4*i +: 4];
      end
`ifdef LEADING_ZERO_BLANK_EN
      if ((SEL_W'(i) >= idx_q) && (bcd_q[4*i +: 4] != 4'd0)) begin
        lead_zero_c = 1'b0;
      end
`endif
    end
    seg_d = enc_digit(digit_c);
`ifdef LEADING_ZERO_BLANK_EN
    if ((idx_q != SEL_W'(0)) && lead_zero_c) begin
      seg_d = SEG_BLANK;
    end
`endif
  end

  // Control FSM with registered outputs: capture, 16 shift cycles, 5 emit cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      seg_q   <= SEG_ZERO;
      sel_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          sel_q  <= '0;
          if (start_i) begin
            bin_q   <= product_i;
            bcd_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end else begin
            busy_q  <= 1'b0;
          end
        end
        SHIFT: begin
          bcd_q <= bcd_d;
          bin_q <= bin_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(W - 1)) begin
            idx_q   <= '0;
            state_q <= EMIT;
          end
        end
        EMIT: begin
          seg_q  <= seg_d;
          sel_q  <= idx_q;
          done_q <= 1'b1;
          if (idx_q == SEL_W'(NDIG - 1)) begin
            state_q <= IDLE;
          end else begin
            idx_q   <= idx_q + SEL_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign seg_out_o     = seg_q;
  assign seg_mux_sel_o = sel_q;
  assign done_o        = done_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_prod_bcd_seg_seq.sv
// Testbench for prod_bcd_seg_seq: directed and random products, with a
// decimal-arithmetic reference model feeding a scoreboard. A negedge monitor
// pops one expected digit whenever done is high.
module tb_prod_bcd_seg_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic [15:0] product_i = 16'd0;
  logic [6:0]  seg_out_o;
  logic [2:0]  seg_mux_sel_o;
  logic        done_o;
  logic        busy_o;

  prod_bcd_seg_seq dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .product_i     (product_i),
    .seg_out_o     (seg_out_o),
    .seg_mux_sel_o (seg_mux_sel_o),
    .done_o        (done_o),
    .busy_o        (busy_o)
  );

  always #5 clk = ~clk;

  // Number of rising edges seen so far.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         k;
    int         cyc;
    logic [2:0] sel;
    logic [6:0] seg;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         next_ok = 0;
  logic [6:0] hold_seg = 7'b0000001;

  logic [6:0] enc_tab [0:9] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                7'b0000000, 7'b0000100};

  // Expected segment pattern for decimal digit i of value p.
  function automatic logic [6:0] ref_seg(input int p, input int i);
    int pw;
    int d;
    pw = 1;
    for (int j = 0; j < i; j++) pw = pw * 10;
    d = (p / pw) % 10;
`ifdef LEADING_ZERO_BLANK_EN
    if (i > 0 && p < pw) return 7'b1111111;
`endif
    return enc_tab[d];
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Drive one cycle of stimulus; the model decides whether the edge accepts start.
  task automatic step(input bit s, input logic [15:0] p);
    exp_t e;
    int   k;
    @(negedge clk);
    start_i   = s;
    product_i = p;
    if (s && rst && (cyc + 1 >= next_ok)) begin
      k = cyc + 1;
      for (int i = 0; i < 5; i++) begin
        e.k   = k;
        e.cyc = k + 17 + i;
        e.sel = 3'(i);
        e.seg = ref_seg(int'(p), i);
        sb.push_back(e);
      end
      next_ok = k + 22;
    end
  endtask

  task automatic pulse(input logic [15:0] p, input int gap);
    step(1'b1, p);
    repeat (gap) step(1'b0, 16'($urandom));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_seg"},  int'(seg_out_o),     int'(7'b0000001));
    check({tag, "_sel"},  int'(seg_mux_sel_o), 0);
    check({tag, "_done"}, int'(done_o),        0);
    check({tag, "_busy"}, int'(busy_o),        0);
  endtask

  // Monitor: compare each presented digit against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (sb.size() > 0 && cyc >= sb[0].k) begin
        check("busy_active", int'(busy_o), 1);
      end
      if (done_o) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done @cyc %0d: sel %0d seg %b", cyc, seg_mux_sel_o, seg_out_o);
        end else begin
          e = sb.pop_front();
          check("done_cycle", cyc, e.cyc);
          check("digit_sel", int'(seg_mux_sel_o), int'(e.sel));
          check("digit_seg", int'(seg_out_o), int'(e.seg));
          hold_seg = e.seg;
        end
      end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_done @cyc %0d: got done 0 expected digit %0d at cyc %0d", cyc, e.sel, e.cyc);
      end else if (sb.size() == 0) begin
        check("idle_seg_hold", int'(seg_out_o), int'(hold_seg));
        check("idle_sel", int'(seg_mux_sel_o), 0);
        check("idle_busy", int'(busy_o), 0);
      end
    end
  end

  initial begin
    // Reset and idle behaviour
    repeat (3) @(negedge clk);
    #1 check_reset_outputs("in_reset");
    @(negedge clk);
    rst = 1'b1;
    next_ok = cyc + 1;
    repeat (50) step(1'b0, 16'($urandom));

    // Directed products
    pulse(16'd65025, 30);
    pulse(16'd0, 30);
    pulse(16'd1234, 30);
    pulse(16'd65535, 30);
    pulse(16'd10, 30);

    // Re-pulse at k+5 with a different product is ignored
    step(1'b1, 16'h1111);
    repeat (4) step(1'b0, 16'h0000);
    step(1'b1, 16'h9999);
    repeat (30) step(1'b0, 16'h0000);

    // Reset mid-SHIFT discards the conversion
    step(1'b1, 16'h4321);
    repeat (9) step(1'b0, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    hold_seg = 7'b0000001;
    #1 check_reset_outputs("mid_shift_reset");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    next_ok = cyc + 1;
    repeat (20) step(1'b0, 16'h0000);
    pulse(16'h00FF, 30);

    // Reset mid-EMIT discards the remaining digits
    step(1'b1, 16'd54321);
    repeat (18) step(1'b0, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    hold_seg = 7'b0000001;
    #1 check_reset_outputs("mid_emit_reset");
    @(negedge clk);
    rst = 1'b1;
    next_ok = cyc + 1;
    repeat (20) step(1'b0, 16'h0000);

    // Start held high: back-to-back conversions
    repeat (80) step(1'b1, 16'($urandom));
    repeat (30) step(1'b0, 16'h0000);

    // Random start pulses and products
    repeat (400) step($urandom_range(0, 7) == 0, 16'($urandom));
    repeat (30) step(1'b0, 16'h0000);

    check("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prod_bcd_seg_seq.md
# prod_bcd_seg_seq

Sequential binary-to-seven-segment converter that sits directly upstream of the per-digit segment latches in the 8x8 multiplier display path. On `start` it captures the 16-bit product and converts it to five BCD digits with a shift-add-3 (double-dabble) engine. It then presents one encoded digit per cycle on `seg_out`, with the matching `seg_mux_sel` index and `done` asserted, so each digit register latches its own pattern.

## Interface
- `W`, default 16: product width; fixed at 16 for five digits (max 65535).
- `NDIG`, default 5: number of digits emitted; `seg_mux_sel` counts 0..`NDIG`-1.
- `clk` input, 1: clock, rising edge.
- `rst` input, 1: reset, asynchronous, active-low.
- `start` input, 1: conversion request, sampled only in IDLE.
- `product` input, 16: unsigned multiplier result, captured on accepted `start`.
- `seg_out` output, 7: segment pattern {a,b,c,d,e,f,g}, active-low (common anode).
- `seg_mux_sel` output, 3: digit index for `seg_out` (0 = units ... 4 = ten-thousands).
- `done` output, 1: high while `seg_out`/`seg_mux_sel` carry a valid digit.
- `busy` output, 1: high from accepted `start` until return to IDLE.

## Operation
- All outputs are registered. Reset values:
  - `seg_out`=7'b0000001
  - `seg_mux_sel`=3'd0
  - `done`=0
  - `busy`=0
  - internal state IDLE, shift counter 0, BCD accumulator 0
- FSM states: IDLE -> SHIFT -> EMIT -> IDLE.
- IDLE: if `start`=1, load the shift register with `product`, clear the 20-bit BCD accumulator and counter, set `busy`, go to SHIFT.
- SHIFT: 16 iterations, one per cycle.
  - Each iteration first adds 3 to every BCD nibble that is >=5.
  - Then it shifts {bcd, bin} left by 1.
  - After the 16th iteration go to EMIT with digit index 0.
- EMIT: 5 cycles. Each cycle drives `seg_out`=enc(digit[idx]), `seg_mux_sel`=idx and `done`=1. idx increments 0..4. After idx 4, go to IDLE, clear `done` and `busy`, and reset `seg_mux_sel` to 0.
- `seg_out` holds its last value outside EMIT.
- Encoding:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - blank=1111111; any nibble >9 (unreachable) encodes as blank.
- `start` while `busy`=1 is ignored; no queueing.
- `product` changes after capture have no effect on the conversion in progress.
- `start` held high continuously: a new conversion is accepted on the first IDLE cycle after each EMIT.

## Timing
- Accepted `start` at edge k.
- SHIFT occupies edges k+1..k+16.
- EMIT outputs update at edges k+17..k+21: `done`=1 and `seg_mux_sel`=0,1,2,3,4 respectively.
- At edge k+22, `done`=0 and `busy`=0. The earliest next accepted `start` is at edge k+22.
- Latency from start to the units digit is 17 cycles; total occupancy is 22 cycles.
- `seg_mux_sel` and `seg_out` change on the same edge, so a downstream latch sees a consistent pair whenever `done`=1.
- Asserting `rst` mid-SHIFT or mid-EMIT forces all reset values immediately. The partial conversion is discarded and no further `done` is produced.

## Configuration
- `LEADING_ZERO_BLANK_EN` defined:
  - During EMIT, a digit with index >0 whose value and all higher-index digits are zero outputs blank (1111111).
  - Digit 0 is never blanked, so product 0 shows a single "0".
- `LEADING_ZERO_BLANK_EN` undefined: all five digits are always encoded, leading zeros included.

## Test plan
- Reset, then idle: outputs are 0000001/0/0/0 and stay constant with `start`=0 for 50 cycles.
- `product`=65025 (0xFE01), `start` 1 cycle:
  - `done` high exactly cycles k+17..k+21.
  - `seg_mux_sel` 0..4.
  - `seg_out` = 0100100, 0010010, 0000001, 0100100, 0100000 (5,2,0,5,6).
- `product`=0:
  - Macro undefined: five digits all 0000001.
  - Macro defined: 0000001, then 1111111 x4.
- `product`=1234:
  - Digits 4,3,2,1,0 give 1001100, 0000110, 0010010, 1001111, then 0000001 (1111111 with macro defined).
- `start` re-pulsed at k+5 with a different `product`: ignored, and the output digits match the first product.
- `rst` low at k+10 (mid-SHIFT):
  - Outputs return to reset values immediately and no `done` appears.
  - After release, a new `start` with 0x00FF yields 5,5,2,0,0.
